// File: rtl/mul_sched_pkg.sv
// Shared types, widths and the signed multiplier datapath for mul_scheduler.
package mul_sched_pkg;

    localparam int OP_W    = 32;
    localparam int PROD_W  = 64;
    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_t;

    // Both operands are sign-extended to full product width first, so the result is exact for every input pair.
    function automatic logic signed [PROD_W-1:0] mul_s32(input logic signed [OP_W-1:0] a,
                                                         input logic signed [OP_W-1:0] b);
        logic signed [PROD_W-1:0] ea;
        logic signed [PROD_W-1:0] eb;
        ea = PROD_W'(a);
        eb = PROD_W'(b);
        return ea * eb;
    endfunction

endpackage

// File: rtl/mul_rr_arb.sv
// Round-robin arbiter: grants the first requester at or above rr_ptr, wrapping modulo NUM_REQ.
module mul_rr_arb #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               update,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic [ID_W-1:0] rr_ptr;

    always_comb begin
        int  j;
        logic found;
        j         = 0;
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = ID_W'(j);
            end
        end
    end

    // The pointer moves just past the winner, so the winner is searched last next time.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (update) begin
            if (grant_idx == ID_W'(NUM_REQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_idx + ID_W'(1);
            end
        end
    end

endmodule

// File: rtl/mul_scheduler.sv
// Shares one signed 32x32 multiplier between NUM_REQ requesters with round-robin arbitration.
// Optional MUL_SCHED_ZERO_BYPASS_EN answers zero-operand requests without waiting for the multiplier.
module mul_scheduler
    import mul_sched_pkg::*;
#(
    parameter int  NUM_REQ    = 2,
    parameter int  MUL_CYCLES = 4,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [OP_W*NUM_REQ-1:0]   req_a,
    input  logic [OP_W*NUM_REQ-1:0]   req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [PROD_W-1:0]         rsp_product,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      busy
);

    localparam int CNT_W = 5;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [OP_W-1:0]    op_a;
    logic [OP_W-1:0]    op_b;
    logic [OP_W-1:0]    sel_a;
    logic [OP_W-1:0]    sel_b;
    logic [ID_W-1:0]    id_q;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               accept;
    logic               bypass;
    logic               rsp_valid_q;
    logic [PROD_W-1:0]  product;

    mul_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .update    (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*OP_W +: OP_W];
                sel_b = req_b[i*OP_W +: OP_W];
            end
        end
    end

    // Outputs are forced quiet during the reset cycle so an in-flight result never leaks out.
    assign req_ready   = (state == IDLE && !rst) ? grant : '0;
    assign accept      = |(req_valid & req_ready);
    assign busy        = (state != IDLE) && !rst;
    assign rsp_valid   = rsp_valid_q && !rst;
    assign rsp_id      = id_q;

    // Multicycle path: op_a/op_b hold still for MUL_CYCLES cycles before the product is sampled.
    assign product = mul_s32(op_a, op_b);

`ifdef MUL_SCHED_ZERO_BYPASS_EN
    assign bypass = (sel_a == '0) || (sel_b == '0);
`else
    assign bypass = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            op_a        <= '0;
            op_b        <= '0;
            id_q        <= '0;
            rsp_product <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_a <= sel_a;
                        op_b <= sel_b;
                        id_q <= grant_idx;
                        cnt  <= '0;
                        if (bypass) begin
                            rsp_product <= '0;
                            rsp_valid_q <= 1'b1;
                            state       <= RESP;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(MUL_CYCLES - 1)) begin
                        rsp_product <= product;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_scheduler.sv
// Self-checking bench for mul_scheduler: transaction-level model compared every cycle plus literal checks.
module tb_mul_scheduler;

    localparam int NUM_REQ    = 2;
    localparam int MUL_CYCLES = 4;
    localparam int ID_W       = $clog2(NUM_REQ);
`ifdef MUL_SCHED_ZERO_BYPASS_EN
    localparam int BYP_LAT = 1;
`else
    localparam int BYP_LAT = MUL_CYCLES + 1;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [32*NUM_REQ-1:0]   req_a;
    logic [32*NUM_REQ-1:0]   req_b;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [63:0]             rsp_product;
    logic [ID_W-1:0]         rsp_id;
    logic                    busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    bit          m_busy = 1'b0;
    bit          m_resp = 1'b0;
    int          m_ptr  = 0;
    int          m_wait = 0;
    int          m_id   = 0;
    logic [63:0] m_prod = '0;

    logic [63:0] log_prod[$];
    int          log_id[$];

    mul_scheduler #(
        .NUM_REQ    (NUM_REQ),
        .MUL_CYCLES (MUL_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_product (rsp_product),
        .rsp_id      (rsp_id),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] mdlMul(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    function automatic int expGrant();
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_valid[(m_ptr + k) % NUM_REQ]) begin
                return (m_ptr + k) % NUM_REQ;
            end
        end
        return -1;
    endfunction

    // Transaction model: one job at a time, fixed countdown to the response, pointer just past the winner.
    always @(posedge clk) begin
        int g;
        if (rst) begin
            m_busy = 1'b0;
            m_resp = 1'b0;
            m_ptr  = 0;
            m_wait = 0;
        end else if (!m_busy) begin
            g = expGrant();
            if (g >= 0) begin
                m_busy = 1'b1;
                m_id   = g;
                m_prod = mdlMul(req_a[32*g +: 32], req_b[32*g +: 32]);
                m_ptr  = (g + 1) % NUM_REQ;
                m_wait = MUL_CYCLES;
`ifdef MUL_SCHED_ZERO_BYPASS_EN
                if (req_a[32*g +: 32] == 32'd0 || req_b[32*g +: 32] == 32'd0) begin
                    m_wait = 0;
                end
`endif
                m_resp = (m_wait == 0);
            end
        end else if (!m_resp) begin
            m_wait--;
            if (m_wait == 0) begin
                m_resp = 1'b1;
            end
        end else if (rsp_ready) begin
            m_busy = 1'b0;
            m_resp = 1'b0;
        end
        cyc++;
    end

    always @(negedge clk) begin
        int g;
        logic [NUM_REQ-1:0] exp_ready;
        if (chk_en) begin
            g = expGrant();
            exp_ready = '0;
            if (!rst && !m_busy && g >= 0) begin
                exp_ready[g] = 1'b1;
            end
            checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
            checkOutput("busy", 64'(busy), 64'(m_busy && !rst));
            checkOutput("rsp_valid", 64'(rsp_valid), 64'(m_resp && !rst));
            if (m_resp && !rst) begin
                checkOutput("rsp_product", rsp_product, m_prod);
                checkOutput("rsp_id", 64'(rsp_id), 64'(m_id));
            end
        end
        if (!rst && rsp_valid === 1'b1 && rsp_ready) begin
            log_prod.push_back(rsp_product);
            log_id.push_back(int'(rsp_id));
        end
    end

    task automatic syncIn();
        @(posedge clk);
        #1;
    endtask

    task automatic waitAccept(input int r, output int acc);
        acc = -1;
        for (int n = 0; n < 200 && acc < 0; n++) begin
            @(negedge clk);
            if (req_ready[r] === 1'b1) begin
                acc = cyc;
            end
        end
        if (acc < 0) begin
            checkOutput("accept_timeout", 64'd0, 64'd1);
        end
        syncIn();
        req_valid[r] = 1'b0;
    endtask

    task automatic applyStimulus(input int r, input logic [31:0] a, input logic [31:0] b, output int acc);
        req_a[32*r +: 32] = a;
        req_b[32*r +: 32] = b;
        req_valid[r]      = 1'b1;
        waitAccept(r, acc);
    endtask

    task automatic waitResp(output int vcyc);
        vcyc = -1;
        for (int n = 0; n < 200 && vcyc < 0; n++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                vcyc = cyc;
            end
        end
        if (vcyc < 0) begin
            checkOutput("rsp_timeout", 64'd0, 64'd1);
        end
    endtask

    task automatic waitLog(input int target);
        int n;
        n = 0;
        while (log_prod.size() < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (log_prod.size() < target) begin
            checkOutput("log_timeout", 64'(log_prod.size()), 64'(target));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        int vc;
        int base;
        logic [63:0] exp_fair[6];
        int          exp_fair_id[6];

        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        @(posedge clk);
        chk_en = 1'b1;
        syncIn();
        rst = 1'b0;

        // Pin the model's arithmetic with hand-computed products.
        checkOutput("model_neg", mdlMul(32'd7, 32'hFFFF_FFFD), 64'hFFFF_FFFF_FFFF_FFEB);
        checkOutput("model_minsq", mdlMul(32'h8000_0000, 32'h8000_0000), 64'h4000_0000_0000_0000);
        checkOutput("model_min_one", mdlMul(32'h8000_0000, 32'd1), 64'hFFFF_FFFF_8000_0000);

        @(negedge clk);
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
        checkOutput("reset_product", rsp_product, 64'd0);
        checkOutput("reset_id", 64'(rsp_id), 64'd0);

        // Single operation: 7 * -3 from requester 0.
        syncIn();
        base = log_prod.size();
        applyStimulus(0, 32'd7, 32'hFFFF_FFFD, acc);
        waitResp(vc);
        checkOutput("single_latency", 64'(vc - acc), 64'(MUL_CYCLES + 1));
        @(negedge clk);
        checkOutput("single_valid_drop", 64'(rsp_valid), 64'd0);
        waitLog(base + 1);
        checkOutput("single_product", log_prod[base], 64'hFFFF_FFFF_FFFF_FFEB);
        checkOutput("single_id", 64'(log_id[base]), 64'd0);

        // Corner operands, alternating requesters so the pointer ends back at 0.
        syncIn();
        base = log_prod.size();
        applyStimulus(1, 32'h8000_0000, 32'h8000_0000, acc);
        applyStimulus(0, 32'h7FFF_FFFF, 32'h8000_0000, acc);
        applyStimulus(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, acc);
        waitLog(base + 3);
        checkOutput("corner_minsq", log_prod[base], 64'h4000_0000_0000_0000);
        checkOutput("corner_max_min", log_prod[base+1], 64'hC000_0000_8000_0000);
        checkOutput("corner_neg1sq", log_prod[base+2], 64'd1);

        // Fairness: both requesters valid back-to-back, three ops each with operands (r+1, k).
        syncIn();
        base = log_prod.size();
        fork
            begin : fair0
                int a0;
                for (int k = 1; k <= 3; k++) applyStimulus(0, 32'd1, 32'(k), a0);
            end
            begin : fair1
                int a1;
                for (int k = 1; k <= 3; k++) applyStimulus(1, 32'd2, 32'(k), a1);
            end
        join
        waitLog(base + 6);
        exp_fair    = '{64'd1, 64'd2, 64'd2, 64'd4, 64'd3, 64'd6};
        exp_fair_id = '{0, 1, 0, 1, 0, 1};
        for (int i = 0; i < 6; i++) begin
            checkOutput("fair_id", 64'(log_id[base+i]), 64'(exp_fair_id[i]));
            checkOutput("fair_product", log_prod[base+i], exp_fair[i]);
        end

        // Backpressure: hold the response for 10 cycles, then release once.
        syncIn();
        rsp_ready = 1'b0;
        base = log_prod.size();
        applyStimulus(0, 32'd123456789, 32'hFFFF_FC18, acc);
        waitResp(vc);
        repeat (10) @(negedge clk);
        checkOutput("bp_held_busy", 64'(busy), 64'd1);
        checkOutput("bp_no_delivery", 64'(log_prod.size()), 64'(base));
        syncIn();
        rsp_ready = 1'b1;
        waitLog(base + 1);
        repeat (8) @(negedge clk);
        checkOutput("bp_one_delivery", 64'(log_prod.size()), 64'(base + 1));
        checkOutput("bp_product", log_prod[base], 64'hFFFF_FFE3_4166_E5F8);

        // Zero operand: full latency normally, one cycle with the bypass build.
        syncIn();
        base = log_prod.size();
        applyStimulus(1, 32'd0, 32'd12345, acc);
        waitResp(vc);
        checkOutput("bypass_latency", 64'(vc - acc), 64'(BYP_LAT));
        waitLog(base + 1);
        checkOutput("bypass_product", log_prod[base], 64'd0);
        checkOutput("bypass_id", 64'(log_id[base]), 64'd1);

        // Reset two cycles after accept: nothing delivered, pointer back to 0.
        syncIn();
        applyStimulus(0, 32'd100, 32'd200, acc);
        syncIn();
        base = log_prod.size();
        rst = 1'b1;
        syncIn();
        rst = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("reset_no_rsp", 64'(log_prod.size()), 64'(base));
        syncIn();
        req_a[31:0]  = 32'd5;
        req_b[31:0]  = 32'd6;
        req_a[63:32] = 32'd9;
        req_b[63:32] = 32'hFFFF_FFFE;
        req_valid    = 2'b11;
        @(negedge clk);
        checkOutput("reset_ptr_grant", 64'(req_ready), 64'b01);
        syncIn();
        req_valid[0] = 1'b0;
        waitAccept(1, acc);
        waitLog(base + 2);
        checkOutput("post_reset_id0", 64'(log_id[base]), 64'd0);
        checkOutput("post_reset_prod0", log_prod[base], 64'd30);
        checkOutput("post_reset_id1", 64'(log_id[base+1]), 64'd1);
        checkOutput("post_reset_prod1", log_prod[base+1], 64'hFFFF_FFFF_FFFF_FFEE);

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
